stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Clk  in  1  rising-edge clock.
REQ-003 Rst  in  1  asynchronous active-high reset.
REQ-004 Op_Valid  in  1  request strobe; sampled only when Busy=0.
REQ-005 Op  in  2  operation: 00 PUSH, 01 POP, 10 CALL, 11 RET.
REQ-006 Data_In  in  8  PUSH value, or CALL return address.
REQ-007 Target  in  8  CALL destination address.
REQ-008 X  in  8  stack read data from data memory (mem[Sp]).
REQ-009 Sp  out  8  stack pointer driven to data memory.
REQ-010 W_Sp  out  1  stack write strobe to data memory.
REQ-011 WD  out  8  stack write data to data memory.
REQ-012 Data_Out  out  8  last popped value, registered.
REQ-013 Pc_Next  out  8  PC redirect value; valid while Pc_Load=1.
REQ-014 Pc_Load  out  1  one-cycle PC redirect pulse.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Done  out  1  one-cycle completion pulse.
REQ-017 Fault  out  1  one-cycle guard-violation pulse; tied 0 without STACK_GUARD_EN.

Function
REQ-018 The stack SHALL be full-descending, post-decrement: PUSH writes mem[SP] then SP-1; POP uses SP+1 then reads.
REQ-019 FSM states SHALL be IDLE, WRITE, INC, READ, DONE.
REQ-020 IDLE with Op_Valid=1: PUSH/CALL SHALL go to WRITE, and POP/RET SHALL go to INC; Op and Data_In are latched at the accepting edge.
REQ-021 In WRITE, W_Sp SHALL be 1, Sp SHALL equal the current SP, and WD SHALL equal the latched data; at the end of WRITE, SP SHALL be SP-1 and the next state SHALL be DONE.
REQ-022 In INC, W_Sp SHALL be 0; at the end of INC, SP SHALL be SP+1 and the next state SHALL be READ.
REQ-023 In READ, Sp SHALL equal the incremented SP; at the end of READ, X SHALL be captured into Data_Out (POP) or Pc_Next (RET), and the next state SHALL be DONE.
REQ-024 In DONE, Done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 Latency: Done SHALL be asserted 2 cycles after acceptance for PUSH/CALL, and 3 cycles after acceptance for POP/RET.
REQ-026 CALL: in DONE, Pc_Load SHALL be 1 and Pc_Next SHALL equal the latched Target.
REQ-027 RET: in DONE, Pc_Load SHALL be 1 and Pc_Next SHALL equal the popped X.
REQ-028 Op_Valid while Busy=1 SHALL be ignored, with no queuing.
REQ-029 W_Sp SHALL be 0 in every state except WRITE.
REQ-030 All SP arithmetic SHALL be 8-bit modulo 256 unless guarded.
REQ-031 Data_Out SHALL hold its value between POPs; a RET SHALL NOT alter Data_Out.

Reset
REQ-032 On Rst=1, the FSM SHALL enter IDLE, SP SHALL be 8'hFF, W_Sp, Done, Pc_Load and Fault SHALL be 0, and Data_Out, Pc_Next and WD SHALL be 8'h00, all immediately and asynchronously.
REQ-033 Reset mid-operation SHALL abort the operation with no partial SP update; a WRITE cut by reset SHALL NOT produce a memory write edge.

Configuration
REQ-034 With STACK_GUARD_EN defined, a PUSH/CALL accepted when SP==STACK_LIMIT SHALL skip WRITE and go directly to DONE with Fault=1, leaving SP unchanged and W_Sp at 0.
REQ-035 With STACK_GUARD_EN defined, a POP/RET accepted when SP==8'hFF SHALL go directly to DONE with Fault=1, leaving SP, Data_Out and Pc_Next unchanged and Pc_Load at 0.
REQ-036 Without STACK_GUARD_EN, SP SHALL wrap freely and Fault SHALL be constant 0.

Structure
REQ-037 Package stack_pkg SHALL hold the op encoding enum, the state enum, SP_RESET (8'hFF) and STACK_LIMIT (8'h80).
REQ-038 The block SHALL be a single module with no sub-module; the FSM and SP register are too tightly coupled to split.

Verification
REQ-039 After reset, PUSH 8'hA5 -> W_Sp=1 with Sp=FF and WD=A5 for one cycle; then SP=FE, and Done pulses 2 cycles after acceptance.
REQ-040 PUSH 11, PUSH 22, POP, POP -> Data_Out=22 then 11, final SP=FF, each Done 3 cycles after POP acceptance.
REQ-041 CALL with Data_In=07 and Target=40 -> mem[FF]=07 and Pc_Load with Pc_Next=40; a following RET -> Pc_Load with Pc_Next=07 and SP=FF.
REQ-042 Op_Valid held high across a PUSH -> exactly one write; a second request is accepted only once back in IDLE.
REQ-043 Rst asserted during WRITE -> W_Sp falls immediately, SP=FF, no Done pulse.
REQ-044 With STACK_GUARD_EN: POP at SP=FF -> Fault and Done pulse, SP stays FF; 127 PUSHes reach SP=80, and the 128th PUSH faults with no write.

Source files
------------

// File: rtl/stack_pkg.sv
// ----------------------------------------------------------------------------
// stack_pkg
// Shared types and constants for the stack controller.
//   op_e        : request encoding (PUSH, POP, CALL, RET)
//   state_e     : controller FSM states
//   SP_RESET    : stack pointer value after reset (empty, full-descending)
//   STACK_LIMIT : lowest SP at which a write is still refused when the
//                 STACK_GUARD_EN overflow/underflow guard is compiled in
// ----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_INC,
        S_READ,
        S_DONE
    } state_e;

    localparam logic [7:0] SP_RESET    = 8'hFF;
    localparam logic [7:0] STACK_LIMIT = 8'h80;

    // PUSH and CALL both store a byte; POP and RET both load one.
    function automatic logic is_write_op(input op_e op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// ----------------------------------------------------------------------------
// stack_ctrl_if
// Request, data-memory and PC-redirect signals of the stack controller.
//   master : requester / data memory side (drives op_valid, op, data_in,
//            target and the memory read data x)
//   slave  : stack_ctrl side (drives sp, w_sp, wd, data_out, pc_next,
//            pc_load, busy, done, fault)
// ----------------------------------------------------------------------------
interface stack_ctrl_if;
    import stack_pkg::*;

    logic       op_valid;
    op_e        op;
    logic [7:0] data_in;
    logic [7:0] target;
    logic [7:0] x;
    logic [7:0] sp;
    logic       w_sp;
    logic [7:0] wd;
    logic [7:0] data_out;
    logic [7:0] pc_next;
    logic       pc_load;
    logic       busy;
    logic       done;
    logic       fault;

    modport master (
        output op_valid, op, data_in, target, x,
        input  sp, w_sp, wd, data_out, pc_next, pc_load, busy, done, fault
    );

    modport slave (
        input  op_valid, op, data_in, target, x,
        output sp, w_sp, wd, data_out, pc_next, pc_load, busy, done, fault
    );

endinterface

// File: rtl/stack_ctrl.sv
// ----------------------------------------------------------------------------
// stack_ctrl
// Full-descending, post-decrement hardware stack controller with CALL/RET
// support. PUSH/CALL: write mem[SP], then SP-1. POP/RET: SP+1, then read.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : stack_ctrl_if.slave (request, data-memory and PC redirect signals)
// Build option:
//   STACK_GUARD_EN : refuse PUSH/CALL at SP==STACK_LIMIT and POP/RET at
//                    SP==SP_RESET, signalling fault instead. Without it SP
//                    wraps modulo 256 and fault is tied low.
// ----------------------------------------------------------------------------
module stack_ctrl
    import stack_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    stack_ctrl_if.slave  bus
);

    state_e     state, next_state;
    op_e        op_q;
    logic [7:0] sp_q;
    logic [7:0] wd_q;
    logic [7:0] target_q;
    logic [7:0] data_out_q;
    logic [7:0] pc_next_q;
    logic       fault_q;
    logic       accept;
    logic       guard_trip;

    assign accept = (state == S_IDLE) && bus.op_valid;

`ifdef STACK_GUARD_EN
    assign guard_trip = is_write_op(bus.op) ? (sp_q == STACK_LIMIT)
                                            : (sp_q == SP_RESET);
`else
    assign guard_trip = 1'b0;
`endif

    // NOTE: asynchronous reset in the sensitivity list; all state uses <= so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state defaults to the current state before the case, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.op_valid) begin
                    if (guard_trip)                next_state = S_DONE;
                    else if (is_write_op(bus.op))  next_state = S_WRITE;
                    else                           next_state = S_INC;
                end
            end
            S_WRITE: next_state = S_DONE;
            S_INC:   next_state = S_READ;
            S_READ:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // SP and result registers only change at the end of a state, so a reset
    // that cuts an operation short leaves no partial update behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q       <= SP_RESET;
            op_q       <= OP_PUSH;
            wd_q       <= 8'h00;
            target_q   <= 8'h00;
            data_out_q <= 8'h00;
            pc_next_q  <= 8'h00;
            fault_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= bus.op;
                wd_q     <= bus.data_in;
                target_q <= bus.target;
                fault_q  <= guard_trip;
            end
            case (state)
                S_WRITE: begin
                    sp_q <= sp_q - 8'd1;
                    if (op_q == OP_CALL) pc_next_q <= target_q;
                end
                S_INC: sp_q <= sp_q + 8'd1;
                S_READ: begin
                    // RET redirects the PC and leaves the POP result alone.
                    if (op_q == OP_POP) data_out_q <= bus.x;
                    else                pc_next_q  <= bus.x;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from registered state, so reset clears them at once.
    assign bus.sp       = sp_q;
    assign bus.wd       = wd_q;
    assign bus.w_sp     = (state == S_WRITE);
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.data_out = data_out_q;
    assign bus.pc_next  = pc_next_q;
    assign bus.pc_load  = (state == S_DONE) && !fault_q &&
                          ((op_q == OP_CALL) || (op_q == OP_RET));
`ifdef STACK_GUARD_EN
    assign bus.fault    = (state == S_DONE) && fault_q;
`else
    assign bus.fault    = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stack_ctrl
// Self-checking bench for stack_ctrl: directed scenarios followed by random
// PUSH/POP/CALL/RET traffic, compared against a byte-array stack model.
// Guard scenarios are included when STACK_GUARD_EN is defined.
// ----------------------------------------------------------------------------
module tb_stack_ctrl;
    import stack_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_ctrl_if bus ();

    stack_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory attached to the stack port.
    logic [7:0] mem [256];
    int         wr_count = 0;
    always @(posedge clk) begin
        if (bus.w_sp) begin
            mem[bus.sp] <= bus.wd;
            wr_count    <= wr_count + 1;
        end
    end
    assign bus.x = mem[bus.sp];

    // Reference model state.
    logic [7:0] m_mem [256];
    logic [7:0] m_sp;
    logic [7:0] m_dout;
    logic [7:0] m_pc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.op_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_sp   = 8'hFF;
        m_dout = 8'h00;
        m_pc   = 8'h00;
    endtask

    // Issue one request at a negedge and follow it to completion.
    task automatic run_op(input op_e o, input logic [7:0] din, input logic [7:0] tgt, input bit hold);
        bit         is_wr, exp_fault, exp_load;
        int         exp_lat, lat, writes, wr_before, exp_writes;
        logic [7:0] exp_wsp;

        is_wr     = (o == OP_PUSH) || (o == OP_CALL);
        exp_fault = 1'b0;
`ifdef STACK_GUARD_EN
        exp_fault = is_wr ? (m_sp == 8'h80) : (m_sp == 8'hFF);
`endif
        exp_wsp    = m_sp;
        exp_load   = !exp_fault && ((o == OP_CALL) || (o == OP_RET));
        exp_writes = (is_wr && !exp_fault) ? 1 : 0;
        if (exp_fault) begin
            exp_lat = 1;
        end else if (is_wr) begin
            m_mem[m_sp] = din;
            m_sp        = m_sp - 8'd1;
            exp_lat     = 2;
            if (o == OP_CALL) m_pc = tgt;
        end else begin
            m_sp    = m_sp + 8'd1;
            exp_lat = 3;
            if (o == OP_POP) m_dout = m_mem[m_sp];
            else             m_pc   = m_mem[m_sp];
        end

        check("idle_before", bus.busy, 1'b0);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.data_in  = din;
        bus.target   = tgt;
        wr_before    = wr_count;
        writes       = 0;
        lat          = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (!hold) bus.op_valid = 1'b0;
            if (c == 1) check("busy", bus.busy, 1'b1);
            if (bus.w_sp) begin
                writes++;
                check("w_addr", bus.sp, exp_wsp);
                check("w_data", bus.wd, din);
            end
            if (bus.done) begin
                lat = c;
                check("pc_load", bus.pc_load, exp_load);
                check("pc_next", bus.pc_next, m_pc);
                check("fault", bus.fault, exp_fault);
                break;
            end
        end
        check("latency", lat, exp_lat);
        check("writes", writes, exp_writes);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check("idle_after", bus.busy, 1'b0);
        check("done_pulse", bus.done, 1'b0);
        check("sp", bus.sp, m_sp);
        check("data_out", bus.data_out, m_dout);
        check("mem_writes", wr_count - wr_before, exp_writes);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrb;
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = OP_PUSH;
        bus.data_in  = 8'h00;
        bus.target   = 8'h00;
        m_sp   = 8'hFF;
        m_dout = 8'h00;
        m_pc   = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("rst_sp", bus.sp, 8'hFF);
        check("rst_w_sp", bus.w_sp, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_pc_load", bus.pc_load, 1'b0);
        check("rst_fault", bus.fault, 1'b0);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_pc_next", bus.pc_next, 8'h00);
        check("rst_wd", bus.wd, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;

        // Single PUSH after reset.
        run_op(OP_PUSH, 8'hA5, 8'h00, 1'b0);
        check("push_sp", bus.sp, 8'hFE);
        check("push_mem", mem[8'hFF], 8'hA5);

        // Two pushes then two pops.
        do_reset();
        run_op(OP_PUSH, 8'h11, 8'h00, 1'b0);
        run_op(OP_PUSH, 8'h22, 8'h00, 1'b0);
        run_op(OP_POP, 8'h00, 8'h00, 1'b0);
        check("pop1", bus.data_out, 8'h22);
        run_op(OP_POP, 8'h00, 8'h00, 1'b0);
        check("pop2", bus.data_out, 8'h11);
        check("pop_sp", bus.sp, 8'hFF);

        // CALL then RET; RET must leave data_out untouched.
        do_reset();
        run_op(OP_CALL, 8'h07, 8'h40, 1'b0);
        check("call_mem", mem[8'hFF], 8'h07);
        check("call_pc", bus.pc_next, 8'h40);
        run_op(OP_RET, 8'h00, 8'h00, 1'b0);
        check("ret_pc", bus.pc_next, 8'h07);
        check("ret_sp", bus.sp, 8'hFF);
        check("ret_dout", bus.data_out, 8'h00);

        // Request strobe held high across the whole operation.
        run_op(OP_PUSH, 8'h3C, 8'h00, 1'b1);
        run_op(OP_PUSH, 8'h4D, 8'h00, 1'b1);

        // Reset asserted in the middle of WRITE.
        do_reset();
        bus.op_valid = 1'b1;
        bus.op       = OP_PUSH;
        bus.data_in  = 8'h5A;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check("cut_w_sp_before", bus.w_sp, 1'b1);
        wrb = wr_count;
        rst = 1'b1;
        #1;
        check("cut_w_sp", bus.w_sp, 1'b0);
        check("cut_sp", bus.sp, 8'hFF);
        check("cut_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        check("cut_done", bus.done, 1'b0);
        check("cut_writes", wr_count - wrb, 0);
        @(negedge clk);
        rst = 1'b0;
        m_sp   = 8'hFF;
        m_dout = 8'h00;
        m_pc   = 8'h00;
        @(posedge clk);
        #1;
        check("cut_done_after", bus.done, 1'b0);
        check("cut_sp_after", bus.sp, 8'hFF);
        @(negedge clk);

`ifdef STACK_GUARD_EN
        // Underflow and overflow guards.
        do_reset();
        run_op(OP_POP, 8'h00, 8'h00, 1'b0);
        check("guard_pop_sp", bus.sp, 8'hFF);
        for (int i = 0; i < 127; i++) run_op(OP_PUSH, 8'(i), 8'h00, 1'b0);
        check("guard_fill_sp", bus.sp, 8'h80);
        run_op(OP_PUSH, 8'hEE, 8'h00, 1'b0);
        check("guard_push_sp", bus.sp, 8'h80);
        do_reset();
`endif

        // Random traffic kept within the populated part of the stack.
        for (int n = 0; n < 60; n++) begin
            op_e        o;
            logic [7:0] depth;
            depth = 8'hFF - m_sp;
            o = op_e'($urandom_range(0, 3));
            if (depth == 8'd0 && !is_write_op(o)) o = (o == OP_POP) ? OP_PUSH : OP_CALL;
            if (depth >= 8'd100 && is_write_op(o)) o = OP_POP;
            run_op(o, 8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
